i2c_regfile_slave: RTL and testbench

I2C_REGFILE_SLAVE -- requirements
Module: i2c_regfile_slave

---
 rtl/i2c_regfile_slave.sv | 253 +++++++++++++++++++++++++
 tb/tb_i2c_regfile_slave.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_regfile_slave.sv
// I2C slave exposing NUM_REGS 8-bit registers behind a one-byte pointer.
// A write frame sends the pointer byte and then data bytes. A read frame
// returns data starting at the last loaded pointer.
// Optional feature: define I2C_REGFILE_AUTOINC_EN to make the pointer advance
// (with wrap) after every data byte. Without it the pointer holds.
module i2c_regfile_slave #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h55,
  parameter int unsigned NUM_REGS   = 4,
  parameter logic [7:0]  RESET_VAL  = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scl,
  input  logic                  sda_in,
  output logic                  sda_out,
  output logic                  sda_oe,
  output logic [NUM_REGS*8-1:0] reg_q,
  output logic [NUM_REGS-1:0]   reg_wr,
  output logic                  busy
);

  localparam int unsigned       PTR_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [8:0]        NUM_REGS_W = 9'(NUM_REGS);
  localparam logic [PTR_W-1:0]  PTR_LAST   = PTR_W'(NUM_REGS - 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  state_t                       state, state_nxt;
  logic [3:0]                   bit_cnt, bit_cnt_nxt;
  logic [7:0]                   shreg, shreg_nxt;
  logic [PTR_W-1:0]             ptr, ptr_nxt, ptr_inc;
  logic                         rw, rw_nxt;
  logic                         m_nack, m_nack_nxt;
  logic                         oe_nxt, out_nxt;
  logic                         wr_en;
  logic [7:0]                   rx_byte, rd_byte;
  logic [NUM_REGS-1:0][7:0]     regs;

  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;
  logic scl_rise, scl_fall, start_det, stop_det;

  // Two-stage synchronisers plus one history stage for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_d <= 1'b1;
      sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_d <= 1'b1;
    end else begin
      scl_s1 <= scl;    scl_s2 <= scl_s1; scl_d <= scl_s2;
      sda_s1 <= sda_in; sda_s2 <= sda_s1; sda_d <= sda_s2;
    end
  end

  // Bus events on the synchronised copies
  always_comb begin
    scl_rise  =  scl_s2 & ~scl_d;
    scl_fall  = ~scl_s2 &  scl_d;
    start_det =  scl_s2 &  scl_d & sda_d & ~sda_s2;
    stop_det  =  scl_s2 &  scl_d & ~sda_d & sda_s2;
    rx_byte   = {shreg[6:0], sda_s2};
  end

  // Read mux: register selected by the pointer
  always_comb begin
    rd_byte = RESET_VAL;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (ptr == PTR_W'(i)) rd_byte = regs[i];
    end
  end

  // Pointer value used after each data byte
  always_comb begin
`ifdef I2C_REGFILE_AUTOINC_EN
    ptr_inc = (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
`else
    ptr_inc = ptr;
`endif
  end

  // FSM state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      ptr     <= '0;
      rw      <= 1'b0;
      m_nack  <= 1'b1;
      sda_oe  <= 1'b0;
      sda_out <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      shreg   <= shreg_nxt;
      ptr     <= ptr_nxt;
      rw      <= rw_nxt;
      m_nack  <= m_nack_nxt;
      sda_oe  <= oe_nxt;
      sda_out <= out_nxt;
      busy    <= (state_nxt != IDLE) && (state_nxt != ADDR);
    end
  end

  // Next-state logic. Bytes are complete once bit_cnt reaches 8 on an SCL
  // rise. The transition into the ACK/next phase then waits for the
  // following SCL fall, so SDA only changes while SCL is low.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    ptr_nxt     = ptr;
    rw_nxt      = rw;
    m_nack_nxt  = m_nack;
    oe_nxt      = sda_oe;
    out_nxt     = sda_out;
    wr_en       = 1'b0;

    if (stop_det) begin
      state_nxt   = IDLE;
      bit_cnt_nxt = '0;
      oe_nxt      = 1'b0;
      out_nxt     = 1'b1;
    end else if (start_det) begin
      state_nxt   = ADDR;
      bit_cnt_nxt = '0;
      oe_nxt      = 1'b0;
      out_nxt     = 1'b1;
    end else begin
      case (state)
        IDLE: ;
        ADDR: begin
          if (scl_rise && bit_cnt < 4'd8) begin
            shreg_nxt   = rx_byte;
            bit_cnt_nxt = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            bit_cnt_nxt = '0;
            if (shreg[7:1] == SLAVE_ADDR) begin
              state_nxt = ADDR_ACK;
              rw_nxt    = shreg[0];
              oe_nxt    = 1'b1;
              out_nxt   = 1'b0;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (rw) begin
              state_nxt = RDATA;
              shreg_nxt = rd_byte;
              oe_nxt    = 1'b1;
              out_nxt   = rd_byte[7];
            end else begin
              state_nxt = PTR;
              oe_nxt    = 1'b0;
              out_nxt   = 1'b1;
            end
          end
        end
        PTR: begin
          if (scl_rise && bit_cnt < 4'd8) begin
            shreg_nxt   = rx_byte;
            bit_cnt_nxt = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            bit_cnt_nxt = '0;
            if ({1'b0, shreg} < NUM_REGS_W) begin
              ptr_nxt   = shreg[PTR_W-1:0];
              state_nxt = PTR_ACK;
              oe_nxt    = 1'b1;
              out_nxt   = 1'b0;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
        PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            state_nxt = WDATA;
            oe_nxt    = 1'b0;
            out_nxt   = 1'b1;
          end
        end
        WDATA: begin
          if (scl_rise && bit_cnt < 4'd8) begin
            shreg_nxt   = rx_byte;
            bit_cnt_nxt = bit_cnt + 4'd1;
            wr_en       = (bit_cnt == 4'd7);
          end else if (scl_fall && bit_cnt == 4'd8) begin
            bit_cnt_nxt = '0;
            ptr_nxt     = ptr_inc;
            state_nxt   = WDATA_ACK;
            oe_nxt      = 1'b1;
            out_nxt     = 1'b0;
          end
        end
        RDATA: begin
          if (scl_rise && bit_cnt < 4'd8) begin
            bit_cnt_nxt = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            bit_cnt_nxt = '0;
            ptr_nxt     = ptr_inc;
            state_nxt   = RDATA_ACK;
            oe_nxt      = 1'b0;
            out_nxt     = 1'b1;
          end else if (scl_fall && bit_cnt != 4'd0) begin
            shreg_nxt = {shreg[6:0], 1'b0};
            out_nxt   = shreg[6];
          end
        end
        RDATA_ACK: begin
          if (scl_rise) begin
            m_nack_nxt = sda_s2;
          end else if (scl_fall) begin
            if (m_nack) begin
              state_nxt = IDLE;
            end else begin
              state_nxt = RDATA;
              shreg_nxt = rd_byte;
              oe_nxt    = 1'b1;
              out_nxt   = rd_byte[7];
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Register file with one-clk write strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs   <= {NUM_REGS{RESET_VAL}};
      reg_wr <= '0;
    end else begin
      reg_wr <= '0;
      if (wr_en) begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
          if (ptr == PTR_W'(i)) begin
            regs[i]   <= rx_byte;
            reg_wr[i] <= 1'b1;
          end
        end
      end
    end
  end

  assign reg_q = regs;

endmodule

// File: tb/tb_i2c_regfile_slave.sv
// Bench for i2c_regfile_slave: bit-banged I2C master, table of single-byte
// write/readback vectors, and hand-written multi-byte, NACK and reset cases.
module tb_i2c_regfile_slave;

  localparam int NR = 4;
  localparam int Q  = 40;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          scl = 1'b1;
  logic          sda_m = 1'b1;
  logic          sda_out, sda_oe, busy;
  logic [NR*8-1:0] reg_q;
  logic [NR-1:0] reg_wr;
  logic          sda_bus;

  assign sda_bus = sda_m & ~(sda_oe & ~sda_out);

  i2c_regfile_slave #(
    .SLAVE_ADDR (7'h55),
    .NUM_REGS   (NR),
    .RESET_VAL  (8'h00)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .scl     (scl),
    .sda_in  (sda_bus),
    .sda_out (sda_out),
    .sda_oe  (sda_oe),
    .reg_q   (reg_q),
    .reg_wr  (reg_wr),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  logic [NR-1:0] wr_log[$];
  logic [7:0]    exp_rd[$];
  bit            oe_seen = 1'b0;

  // Every clk that reg_wr is non-zero is logged, so a 2-clk pulse shows twice
  always @(negedge clk) begin
    if (reg_wr != '0) wr_log.push_back(reg_wr);
    if (sda_oe) oe_seen = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clock_bit(input logic v, output logic s);
    sda_m = v; #Q;
    scl = 1'b1; #Q;
    s = sda_bus; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; #Q;
    scl = 1'b1; #Q;
    sda_m = 1'b0; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q;
    scl = 1'b1; #Q;
    sda_m = 1'b1; #Q; #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic d;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], d);
    clock_bit(1'b1, ack);
  endtask

  task automatic write_bits(input logic [7:0] b, input int hi, input int lo);
    logic d;
    for (int i = hi; i >= lo; i--) clock_bit(b[i], d);
  endtask

  // Reads one byte, then compares it against the scoreboard head
  task automatic read_byte(input logic ack_bit, input string name);
    logic [7:0] b;
    logic d;
    for (int i = 7; i >= 0; i--) clock_bit(1'b1, b[i]);
    clock_bit(ack_bit, d);
    sda_m = 1'b1;
    if (exp_rd.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s: got %h expected <none queued>", name, b);
    end else begin
      check(name, {24'h0, b}, {24'h0, exp_rd.pop_front()});
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; #20;
    rst_n = 1'b1; #20;
  endtask

  typedef struct {
    logic [7:0]  ptr;
    logic [7:0]  data;
    logic        nack;
    logic [31:0] exp_q;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic a;
    logic [31:0] q_before;
    logic [NR-1:0] exp_wr0, exp_wr1;
    logic [7:0] exp_b0, exp_b1;
    logic [31:0] exp_s1;

    vecs[0] = '{8'h00, 8'h11, 1'b0, 32'h0000_0011};
    vecs[1] = '{8'h01, 8'h22, 1'b0, 32'h0000_2211};
    vecs[2] = '{8'h03, 8'h44, 1'b0, 32'h4400_2211};
    vecs[3] = '{8'h04, 8'h99, 1'b1, 32'h4400_2211};
    vecs[4] = '{8'h02, 8'h33, 1'b0, 32'h4433_2211};
    vecs[5] = '{8'hFF, 8'h77, 1'b1, 32'h4433_2211};
    vecs[6] = '{8'h00, 8'hFF, 1'b0, 32'h4433_22FF};

    #3;
    rst_n = 1'b0; #20;
    check("rst_sda_oe", {31'h0, sda_oe}, 32'h0);
    check("rst_sda_out", {31'h0, sda_out}, 32'h1);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_reg_q", reg_q, 32'h0);
    check("rst_reg_wr", {28'h0, reg_wr}, 32'h0);
    rst_n = 1'b1; #20;

    // Table: one pointer + one data byte, then readback when the pointer is legal
    for (int v = 0; v < 7; v++) begin
      wr_log.delete();
      i2c_start();
      write_byte(8'hAA, a);
      check("tbl_addr_ack", {31'h0, a}, 32'h0);
      check("tbl_busy", {31'h0, busy}, 32'h1);
      write_byte(vecs[v].ptr, a);
      check("tbl_ptr_ack", {31'h0, a}, {31'h0, vecs[v].nack});
      write_byte(vecs[v].data, a);
      check("tbl_data_ack", {31'h0, a}, {31'h0, vecs[v].nack});
      i2c_stop();
      check("tbl_busy_idle", {31'h0, busy}, 32'h0);
      check("tbl_reg_q", reg_q, vecs[v].exp_q);
      check("tbl_wr_count", wr_log.size(), vecs[v].nack ? 32'd0 : 32'd1);
      if (!vecs[v].nack && wr_log.size() > 0)
        check("tbl_wr_bit", {28'h0, wr_log[0]}, 32'h1 << vecs[v].ptr);
      if (!vecs[v].nack) begin
        i2c_start();
        write_byte(8'hAA, a);
        write_byte(vecs[v].ptr, a);
        i2c_start();
        write_byte(8'hAB, a);
        check("tbl_rd_addr_ack", {31'h0, a}, 32'h0);
        exp_rd.push_back(vecs[v].data);
        read_byte(1'b1, "tbl_readback");
        i2c_stop();
      end
    end

    // Two data bytes at pointer 2
    do_reset();
    wr_log.delete();
`ifdef I2C_REGFILE_AUTOINC_EN
    exp_s1 = 32'hC35A_0000; exp_wr0 = 4'b0100; exp_wr1 = 4'b1000;
    exp_b0 = 8'hC3; exp_b1 = 8'h00;
`else
    exp_s1 = 32'h00C3_0000; exp_wr0 = 4'b0100; exp_wr1 = 4'b0100;
    exp_b0 = 8'h00; exp_b1 = 8'h00;
`endif
    i2c_start();
    write_byte(8'hAA, a); check("s1_addr_ack", {31'h0, a}, 32'h0);
    write_byte(8'h02, a); check("s1_ptr_ack", {31'h0, a}, 32'h0);
    write_byte(8'h5A, a); check("s1_d0_ack", {31'h0, a}, 32'h0);
    write_byte(8'hC3, a); check("s1_d1_ack", {31'h0, a}, 32'h0);
    i2c_stop();
    check("s1_reg_q", reg_q, exp_s1);
    check("s1_wr_count", wr_log.size(), 32'd2);
    if (wr_log.size() == 2) begin
      check("s1_wr_first", {28'h0, wr_log[0]}, {28'h0, exp_wr0});
      check("s1_wr_second", {28'h0, wr_log[1]}, {28'h0, exp_wr1});
    end

    // Pointer 3, repeated START, read two bytes (ACK then NACK)
    i2c_start();
    write_byte(8'hAA, a);
    write_byte(8'h03, a); check("s2_ptr_ack", {31'h0, a}, 32'h0);
    i2c_start();
    write_byte(8'hAB, a); check("s2_rd_addr_ack", {31'h0, a}, 32'h0);
    exp_rd.push_back(exp_b0);
    read_byte(1'b0, "s2_rd_byte0");
    exp_rd.push_back(exp_b1);
    read_byte(1'b1, "s2_rd_byte1");
    check("s2_idle_busy", {31'h0, busy}, 32'h0);
    check("s2_idle_oe", {31'h0, sda_oe}, 32'h0);
    i2c_stop();
    check("s2_reg_q", reg_q, exp_s1);

    // Foreign address: never drives SDA, never writes
    q_before = reg_q;
    wr_log.delete();
    oe_seen = 1'b0;
    i2c_start();
    write_byte(8'hAC, a); check("s3_addr_nack", {31'h0, a}, 32'h1);
    write_byte(8'h01, a);
    write_byte(8'h77, a);
    i2c_stop();
    check("s3_oe_seen", {31'h0, oe_seen}, 32'h0);
    check("s3_reg_q", reg_q, q_before);
    check("s3_wr_count", wr_log.size(), 32'd0);

    // Reset in the middle of a data byte
    i2c_start();
    write_byte(8'hAA, a);
    write_byte(8'h00, a); check("s4_ptr_ack", {31'h0, a}, 32'h0);
    write_bits(8'hA5, 7, 4);
    rst_n = 1'b0; #20;
    check("s4_rst_reg_q", reg_q, 32'h0);
    check("s4_rst_oe", {31'h0, sda_oe}, 32'h0);
    rst_n = 1'b1; #20;
    wr_log.delete();
    write_bits(8'hA5, 3, 0);
    clock_bit(1'b1, a); check("s4_tail_nack", {31'h0, a}, 32'h1);
    write_byte(8'h66, a); check("s4_next_nack", {31'h0, a}, 32'h1);
    i2c_stop();
    check("s4_reg_q_after", reg_q, 32'h0);
    check("s4_wr_count", wr_log.size(), 32'd0);
    i2c_start();
    write_byte(8'hAA, a); check("s4_new_addr_ack", {31'h0, a}, 32'h0);
    write_byte(8'h01, a);
    write_byte(8'h5A, a);
    i2c_stop();
    check("s4_new_reg_q", reg_q, 32'h0000_5A00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
